fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, IF/ID register, stall/redirect/halt control
// One-cycle fetch latency: instr at each posedge belongs to the pc of the cycle just ending.
module fetch_stage #(
  parameter int                     ADDR_SIZE  = 32,
  parameter int                     WORD_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0]   RESET_PC   = '0,
  parameter int                     IMEM_WORDS = 17,
  parameter logic [WORD_SIZE-1:0]   NOP_WORD   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_addr,
  input  logic [WORD_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] ifid_instr,
  output logic [ADDR_SIZE-1:0] ifid_pc4,
  output logic                 ifid_valid,
  output logic                 halted
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [ADDR_SIZE-1:0] PC_LIMIT = ADDR_SIZE'(IMEM_WORDS * 4);

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_SIZE-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                 ifid_valid_q, ifid_valid_d;

  logic [ADDR_SIZE-1:0] pc_plus4;
  logic [ADDR_SIZE-1:0] target;

  assign pc_plus4 = pc_q + ADDR_SIZE'(4);
  assign target   = {redirect_addr[ADDR_SIZE-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    case (state_q)
      BOOT: begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
        state_d      = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d         = target;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_q >= PC_LIMIT) begin
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
          state_d      = HALT;
        end else begin
          ifid_instr_d = instr;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
        end
      end
      HALT: begin
        // Bubbles keep flowing even under stall; only a redirect restarts fetch.
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
        if (redirect) begin
          pc_d    = target;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
// Stimulus pushes the expected post-edge state; a monitor pops and compares after each posedge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;

  typedef struct {
    string       name;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_halted;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:16];
  int          vectors;
  int          miscompares;

  fetch_stage #(
    .ADDR_SIZE(32), .WORD_SIZE(32), .RESET_PC(32'h0), .IMEM_WORDS(17), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr(instr), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range fetches return a poison word so a halt that wrongly loads it is visible.
  assign instr = (pc < 32'd68) ? mem[pc[6:2]] : 32'hDEADBEEF;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d vectors pending", sb.size());
    $fatal(1, "timeout");
  end

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (ifid_instr !== e.e_instr || ifid_pc4 !== e.e_pc4 || pc !== e.e_pc ||
          ifid_valid !== e.e_valid || halted !== e.e_halted) begin
        miscompares++;
        $display("FAIL %s: got instr=%h pc4=%h pc=%h valid=%b halted=%b, want instr=%h pc4=%h pc=%h valid=%b halted=%b",
                 e.name, ifid_instr, ifid_pc4, pc, ifid_valid, halted,
                 e.e_instr, e.e_pc4, e.e_pc, e.e_valid, e.e_halted);
      end
    end
  end

  // Called at a negedge: drive inputs for the coming edge, queue its expectation, wait one cycle.
  task automatic step(input string name, input logic st, input logic rd, input logic [31:0] ra,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_halted);
    exp_t e;
    stall         = st;
    redirect      = rd;
    redirect_addr = ra;
    e.name = name; e.e_instr = e_instr; e.e_pc4 = e_pc4; e.e_pc = e_pc;
    e.e_valid = e_valid; e.e_halted = e_halted;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic direct_check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem[0] = 32'h20010005;
    mem[1] = 32'h20020003;
    mem[2] = 32'h00221820;
    mem[3] = 32'hAC030000;
    for (int i = 4; i < 17; i++) mem[i] = 32'h24000000 | 32'(i);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    #1;
    direct_check("reset_pc", pc, 32'h0);
    direct_check("reset_valid", {31'b0, ifid_valid}, 32'h0);
    direct_check("reset_halted", {31'b0, halted}, 32'h0);
    direct_check("reset_pc4", ifid_pc4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("boot_bubble", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step("run_w0", 0, 0, 0, mem[0], 32'd4, 32'd4, 1, 0);
    step("run_w1", 0, 0, 0, mem[1], 32'd8, 32'd8, 1, 0);
    for (int i = 0; i < 3; i++) step("stall_hold", 1, 0, 0, mem[1], 32'd8, 32'd8, 1, 0);
    step("stall_release", 0, 0, 0, mem[2], 32'd12, 32'd12, 1, 0);
    step("redirect_over_stall", 1, 1, 32'h0000000E, 32'h0, 32'd12, 32'h0C, 0, 0);
    step("after_redirect", 0, 0, 0, mem[3], 32'd16, 32'd16, 1, 0);
    for (int i = 4; i < 17; i++)
      step("free_run", 0, 0, 0, mem[i], 32'(4*i+4), 32'(4*i+4), 1, 0);
    step("enter_halt", 0, 0, 0, 32'h0, 32'd68, 32'd68, 0, 1);
    for (int i = 0; i < 10; i++)
      step("halt_hold", logic'(i % 2), 0, 0, 32'h0, 32'd68, 32'd68, 0, 1);
    step("halt_redirect", 0, 1, 32'h00000004, 32'h0, 32'd68, 32'd4, 0, 0);
    for (int i = 1; i < 8; i++)
      step("resume_run", 0, 0, 0, mem[i], 32'(4*i+4), 32'(4*i+4), 1, 0);

    // Asynchronous reset in the low phase at pc=0x20, with a stall and redirect pending.
    #2;
    stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h40;
    rst = 1'b1;
    #1;
    direct_check("async_rst_pc", pc, 32'h0);
    direct_check("async_rst_valid", {31'b0, ifid_valid}, 32'h0);
    direct_check("async_rst_halted", {31'b0, halted}, 32'h0);
    direct_check("async_rst_instr", ifid_instr, 32'h0);
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("boot_bubble_again", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step("rerun_w0", 0, 0, 0, mem[0], 32'd4, 32'd4, 1, 0);
    step("redirect_high", 0, 1, 32'h00000047, 32'h0, 32'd4, 32'h44, 0, 0);
    step("redirect_beats_halt", 0, 1, 32'h00000010, 32'h0, 32'd4, 32'h10, 0, 0);
    step("after_oor_redirect", 0, 0, 0, mem[4], 32'd20, 32'd20, 1, 0);

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
